// File: rtl/c1_input_loader.sv
// Frame loader for the C1S2 layer. It writes one pixel frame into the shared data buffers,
// launches the layer, waits for it to finish, and then re-opens the input stream.
module c1_input_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int FRAME_WORDS = 6144,
  parameter int SETTLE_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_din,
  output logic              layer_en,
  input  logic              layer_fin,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_len
);

  localparam int               IDX_W    = $clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam int               SET_W    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_CYC);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_s;
  logic [SET_W-1:0]    settle_r;
  logic [SET_W-1:0]    settle_s;
  logic                err_set_s;
  logic                accept_s;
  logic                fin_rise_s;
  logic                fin_q_r;
  logic                buf_we_r;
  logic [ADDR_W-1:0]   buf_wr_addr_r;
  logic [DATA_W-1:0]   buf_din_r;
  logic                layer_en_r;
  logic                frame_done_r;
  logic [15:0]         frame_cnt_r;
  logic                err_len_r;

  assign accept_s   = s_valid && (state_r == ST_LOAD);
  // Only a low-to-high transition seen inside RUN ends the compute phase.
  assign fin_rise_s = layer_fin && !fin_q_r;

  // Next-state, beat index and settle counter decode
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    settle_s  = settle_r;
    err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_s = ST_LOAD;
          idx_s   = {IDX_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (idx_r == LAST_IDX) begin
            state_s   = ST_SETTLE;
            idx_s     = {IDX_W{1'b0}};
            settle_s  = {SET_W{1'b0}};
            err_set_s = !s_last;
          end else if (s_last) begin
            // A short frame is still written, but the load restarts from address zero.
            idx_s     = {IDX_W{1'b0}};
            err_set_s = 1'b1;
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (settle_r == SET_MAX) begin
          state_s = ST_RUN;
        end else begin
          settle_s = settle_r + SET_W'(1);
        end
      end
      ST_RUN: begin
        if (fin_rise_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, counters and the finish-edge history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= {IDX_W{1'b0}};
      settle_r <= {SET_W{1'b0}};
      fin_q_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      settle_r <= settle_s;
      fin_q_r  <= layer_fin;
    end
  end

  // Buffer write port: one registered write per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_we_r      <= 1'b0;
      buf_wr_addr_r <= {ADDR_W{1'b0}};
      buf_din_r     <= {DATA_W{1'b0}};
    end else begin
      buf_we_r <= accept_s;
      if (accept_s) begin
        buf_wr_addr_r <= ADDR_W'(idx_r);
        buf_din_r     <= s_data;
      end
    end
  end

  // Layer control, completion pulse, frame counter and sticky length error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_en_r   <= 1'b0;
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
      err_len_r    <= 1'b0;
    end else begin
      layer_en_r   <= (state_s == ST_RUN);
      frame_done_r <= (state_s == ST_DONE);
      if ((state_r == ST_RUN) && (state_s == ST_DONE)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (err_set_s) begin
        err_len_r <= 1'b1;
      end
    end
  end

  assign s_ready     = (state_r == ST_LOAD);
  assign busy        = (state_r != ST_IDLE);
  assign buf_we      = buf_we_r;
  assign buf_wr_addr = buf_wr_addr_r;
  assign buf_din     = buf_din_r;
  assign layer_en    = layer_en_r;
  assign frame_done  = frame_done_r;
  assign frame_cnt   = frame_cnt_r;
  assign err_len     = err_len_r;

endmodule

// File: tb/tb_c1_input_loader.sv
// Directed bench for c1_input_loader: a default-size instance (a) and a 16-word-frame instance (b).
module tb_c1_input_loader;

  logic        clk;
  logic        rst_n;
  int          n_tests;
  int          n_fail;

  logic        run_a, s_valid_a, s_last_a, layer_fin_a;
  logic [15:0] s_data_a;
  logic        s_ready_a, buf_we_a, layer_en_a, busy_a, frame_done_a, err_len_a;
  logic [31:0] buf_wr_addr_a;
  logic [15:0] buf_din_a, frame_cnt_a;

  logic        run_b, s_valid_b, s_last_b, layer_fin_b;
  logic [15:0] s_data_b;
  logic        s_ready_b, buf_we_b, layer_en_b, busy_b, frame_done_b, err_len_b;
  logic [31:0] buf_wr_addr_b;
  logic [15:0] buf_din_b, frame_cnt_b;

  c1_input_loader u_dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .s_data(s_data_a), .s_last(s_last_a), .buf_we(buf_we_a), .buf_wr_addr(buf_wr_addr_a),
    .buf_din(buf_din_a), .layer_en(layer_en_a), .layer_fin(layer_fin_a), .busy(busy_a),
    .frame_done(frame_done_a), .frame_cnt(frame_cnt_a), .err_len(err_len_a)
  );

  c1_input_loader #(.FRAME_WORDS(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_data(s_data_b), .s_last(s_last_b), .buf_we(buf_we_b), .buf_wr_addr(buf_wr_addr_b),
    .buf_din(buf_din_b), .layer_en(layer_en_b), .layer_fin(layer_fin_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_cnt(frame_cnt_b), .err_len(err_len_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_we_a"}, 32'(buf_we_a), 32'd0);
    chk({tag, "_addr_a"}, buf_wr_addr_a, 32'd0);
    chk({tag, "_din_a"}, 32'(buf_din_a), 32'd0);
    chk({tag, "_len_a"}, 32'(layer_en_a), 32'd0);
    chk({tag, "_done_a"}, 32'(frame_done_a), 32'd0);
    chk({tag, "_cnt_a"}, 32'(frame_cnt_a), 32'd0);
    chk({tag, "_err_a"}, 32'(err_len_a), 32'd0);
    chk({tag, "_rdy_a"}, 32'(s_ready_a), 32'd0);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
  endtask

  task automatic chk_zero_b(input string tag);
    chk({tag, "_we_b"}, 32'(buf_we_b), 32'd0);
    chk({tag, "_addr_b"}, buf_wr_addr_b, 32'd0);
    chk({tag, "_din_b"}, 32'(buf_din_b), 32'd0);
    chk({tag, "_len_b"}, 32'(layer_en_b), 32'd0);
    chk({tag, "_done_b"}, 32'(frame_done_b), 32'd0);
    chk({tag, "_cnt_b"}, 32'(frame_cnt_b), 32'd0);
    chk({tag, "_err_b"}, 32'(err_len_b), 32'd0);
    chk({tag, "_rdy_b"}, 32'(s_ready_b), 32'd0);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
  endtask

  task automatic do_reset();
    run_a = 1'b0; s_valid_a = 1'b0; s_last_a = 1'b0; layer_fin_a = 1'b0;
    run_b = 1'b0; s_valid_b = 1'b0; s_last_b = 1'b0; layer_fin_b = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Called #1 after the edge that accepted the final beat of a frame on instance b.
  task automatic launch_b(input string tag, input logic [15:0] exp_cnt);
    s_valid_b = 1'b0;
    s_last_b  = 1'b0;
    tick();
    chk({tag, "_we_off"}, 32'(buf_we_b), 32'd0);
    chk({tag, "_en_n1"}, 32'(layer_en_b), 32'd0);
    tick();
    chk({tag, "_en_n2"}, 32'(layer_en_b), 32'd0);
    tick();
    chk({tag, "_en_n3"}, 32'(layer_en_b), 32'd1);
    layer_fin_b = 1'b1;
    tick();
    chk({tag, "_en_fall"}, 32'(layer_en_b), 32'd0);
    chk({tag, "_done"}, 32'(frame_done_b), 32'd1);
    chk({tag, "_cnt"}, 32'(frame_cnt_b), 32'(exp_cnt));
    layer_fin_b = 1'b0;
    tick();
    chk({tag, "_done_off"}, 32'(frame_done_b), 32'd0);
    chk({tag, "_idle"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    s_data_a = 16'd0;
    s_data_b = 16'd0;
    do_reset();
    rst_n = 1'b0;
    tick();
    chk_zero_a("rst");
    chk_zero_b("rst");
    rst_n = 1'b1;

    // Nominal default-size frame
    run_a = 1'b1;
    tick();
    chk("t1_ready", 32'(s_ready_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 6144; i++) begin
      s_valid_a = 1'b1;
      s_data_a  = 16'(10000 + i);
      s_last_a  = (i == 6143);
      tick();
      chk("t1_we", 32'(buf_we_a), 32'd1);
      chk("t1_addr", buf_wr_addr_a, 32'(i));
      chk("t1_din", 32'(buf_din_a), 32'(10000 + i));
    end
    s_valid_a = 1'b0;
    s_last_a  = 1'b0;
    chk("t1_ready_settle", 32'(s_ready_a), 32'd0);
    tick();
    chk("t1_we_off", 32'(buf_we_a), 32'd0);
    chk("t1_en_n1", 32'(layer_en_a), 32'd0);
    tick();
    chk("t1_en_n2", 32'(layer_en_a), 32'd0);
    tick();
    chk("t1_en_n3", 32'(layer_en_a), 32'd1);
    layer_fin_a = 1'b1;
    tick();
    chk("t1_en_fall", 32'(layer_en_a), 32'd0);
    chk("t1_done", 32'(frame_done_a), 32'd1);
    chk("t1_cnt", 32'(frame_cnt_a), 32'd1);
    chk("t1_err", 32'(err_len_a), 32'd0);
    layer_fin_a = 1'b0;
    tick();
    chk("t1_done_off", 32'(frame_done_a), 32'd0);
    chk("t1_idle", 32'(busy_a), 32'd0);
    chk("t1_ready_idle", 32'(s_ready_a), 32'd0);
    tick();
    chk("t1_reopen", 32'(s_ready_a), 32'd1);

    // Reset in the middle of a load; run dropping mid-frame has no effect
    run_a = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      s_valid_a = 1'b1;
      s_data_a  = 16'(20000 + i);
      tick();
    end
    chk("t6a_addr100", buf_wr_addr_a, 32'd100);
    chk("t6a_cnt_before", 32'(frame_cnt_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero_a("t6a");
    s_valid_a = 1'b0;
    tick();
    rst_n = 1'b1;
    run_a = 1'b1;
    tick();
    s_valid_a = 1'b1;
    s_data_a  = 16'd30000;
    tick();
    chk("t6a_we", 32'(buf_we_a), 32'd1);
    chk("t6a_addr0", buf_wr_addr_a, 32'd0);
    chk("t6a_din", 32'(buf_din_a), 32'd30000);
    chk("t6a_cnt", 32'(frame_cnt_a), 32'd0);

    // Gapped input on the 16-word instance
    do_reset();
    run_b = 1'b1;
    tick();
    for (int k = 0; k <= 30; k++) begin
      s_valid_b = (k % 2 == 0);
      s_data_b  = 16'(500 + k / 2);
      s_last_b  = (k == 30);
      tick();
      if (k % 2 == 0) begin
        chk("t2_we", 32'(buf_we_b), 32'd1);
        chk("t2_addr", buf_wr_addr_b, 32'(k / 2));
        chk("t2_din", 32'(buf_din_b), 32'(500 + k / 2));
      end else begin
        chk("t2_gap", 32'(buf_we_b), 32'd0);
      end
    end
    launch_b("t2", 16'd1);
    chk("t2_err", 32'(err_len_b), 32'd0);

    // Early s_last restarts the frame
    do_reset();
    run_b = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) begin
      s_valid_b = 1'b1;
      s_data_b  = 16'(600 + j);
      s_last_b  = (j == 5);
      tick();
      chk("t3_short_addr", buf_wr_addr_b, 32'(j));
    end
    chk("t3_err", 32'(err_len_b), 32'd1);
    chk("t3_still_load", 32'(s_ready_b), 32'd1);
    for (int j = 0; j < 16; j++) begin
      s_valid_b = 1'b1;
      s_data_b  = 16'(700 + j);
      s_last_b  = (j == 15);
      tick();
      chk("t3_addr", buf_wr_addr_b, 32'(j));
      chk("t3_din", 32'(buf_din_b), 32'(700 + j));
      chk("t3_no_launch", 32'(layer_en_b), 32'd0);
    end
    launch_b("t3", 16'd1);

    // Missing s_last still launches after the last word
    do_reset();
    run_b = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) begin
      s_valid_b = 1'b1;
      s_data_b  = 16'(800 + j);
      s_last_b  = 1'b0;
      tick();
      chk("t4_addr", buf_wr_addr_b, 32'(j));
    end
    chk("t4_err", 32'(err_len_b), 32'd1);
    chk("t4_settle", 32'(s_ready_b), 32'd0);
    launch_b("t4", 16'd1);

    // A finish level already high at RUN entry is ignored
    do_reset();
    run_b = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) begin
      s_valid_b = 1'b1;
      s_data_b  = 16'(900 + j);
      s_last_b  = (j == 15);
      tick();
      chk("t5_addr", buf_wr_addr_b, 32'(j));
    end
    s_valid_b   = 1'b0;
    s_last_b    = 1'b0;
    layer_fin_b = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_en_rise", 32'(layer_en_b), 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t5_stale_hi", 32'(layer_en_b), 32'd1);
    end
    layer_fin_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_low", 32'(layer_en_b), 32'd1);
    end
    layer_fin_b = 1'b1;
    tick();
    chk("t5_en_fall", 32'(layer_en_b), 32'd0);
    chk("t5_done", 32'(frame_done_b), 32'd1);
    chk("t5_cnt", 32'(frame_cnt_b), 32'd1);
    chk("t5_err", 32'(err_len_b), 32'd0);
    layer_fin_b = 1'b0;
    tick();
    tick();

    // Reset while the layer is running
    for (int j = 0; j < 16; j++) begin
      s_valid_b = 1'b1;
      s_data_b  = 16'(1000 + j);
      s_last_b  = (j == 15);
      tick();
    end
    s_valid_b = 1'b0;
    s_last_b  = 1'b0;
    tick();
    tick();
    tick();
    chk("t6b_running", 32'(layer_en_b), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero_b("t6b");
    tick();
    rst_n = 1'b1;
    run_b = 1'b1;
    tick();
    s_valid_b = 1'b1;
    s_data_b  = 16'd1100;
    tick();
    chk("t6b_we", 32'(buf_we_b), 32'd1);
    chk("t6b_addr0", buf_wr_addr_b, 32'd0);
    chk("t6b_din", 32'(buf_din_b), 32'd1100);
    chk("t6b_cnt", 32'(frame_cnt_b), 32'd0);
    s_valid_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
